// File: rtl/chan_sel_mux.sv
// rtl/chan_sel_mux.sv - frame-synchronous registered N-channel sample selector (optional auto-scan: CHAN_SEL_MUX_SCAN_EN)
module chan_sel_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 5,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [NCH-1:0]       d_valid,
    input  logic [SELW-1:0]      sel_req,
    input  logic                 sel_load,
    input  logic                 frame_start,
    input  logic                 scan_en,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    output logic [SELW-1:0]      sel_cur,
    output logic                 switch_pulse,
    output logic                 sel_err
);

    typedef enum logic {
        LOCKED  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [SELW:0]   NCH_C = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    state_t            state;
    logic [SELW-1:0]   pend_sel;
    logic              req_ok;
    logic              scan_step;
    logic [SELW-1:0]   sel_eff;
    logic [WIDTH-1:0]  y_nxt;
    logic              yv_nxt;

    // A request is only accepted if it names an existing channel
    assign req_ok = sel_load && ({1'b0, sel_req} < NCH_C);

`ifdef CHAN_SEL_MUX_SCAN_EN
    assign scan_step = scan_en;
`else
    logic scan_en_unused;
    assign scan_en_unused = scan_en;
    assign scan_step      = 1'b0;
`endif

    // Channel in effect this cycle: a same-cycle request beats a held one, which beats scanning
    always_comb begin
        sel_eff = sel_cur;
        if (frame_start) begin
            if (req_ok) begin
                sel_eff = sel_req;
            end else if (state == PENDING) begin
                sel_eff = pend_sel;
            end else if (scan_step) begin
                sel_eff = (sel_cur == LAST) ? '0 : sel_cur + SELW'(1);
            end
        end
    end

    // Sample mux over the real channels; unused select codes never occur
    always_comb begin
        y_nxt  = '0;
        yv_nxt = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_eff == SELW'(k)) begin
                y_nxt  = d[k*WIDTH +: WIDTH];
                yv_nxt = d_valid[k];
            end
        end
    end

    // Request FSM, current selection and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOCKED;
            pend_sel     <= '0;
            sel_cur      <= '0;
            switch_pulse <= 1'b0;
            sel_err      <= 1'b0;
            y            <= '0;
            y_valid      <= 1'b0;
        end else begin
            y            <= y_nxt;
            y_valid      <= yv_nxt;
            sel_cur      <= sel_eff;
            switch_pulse <= frame_start && (sel_eff != sel_cur);
            if (sel_load && !req_ok) begin
                sel_err <= 1'b1;
            end
            case (state)
                LOCKED: begin
                    if (req_ok && !frame_start) begin
                        state    <= PENDING;
                        pend_sel <= sel_req;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        state <= LOCKED;
                    end else if (req_ok) begin
                        pend_sel <= sel_req;
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_sel_mux.sv
// tb/tb_chan_sel_mux.sv - vector table plus randomized model check for chan_sel_mux
module tb_chan_sel_mux;

    localparam int WIDTH = 8;
    localparam int NCH   = 5;
    localparam int SELW  = 3;
`ifdef CHAN_SEL_MUX_SCAN_EN
    localparam int SCAN = 1;
`else
    localparam int SCAN = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] d;
    logic [NCH-1:0]       d_valid;
    logic [SELW-1:0]      sel_req;
    logic                 sel_load;
    logic                 frame_start;
    logic                 scan_en;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic [SELW-1:0]      sel_cur;
    logic                 switch_pulse;
    logic                 sel_err;

    chan_sel_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sel_req(sel_req),
        .sel_load(sel_load), .frame_start(frame_start), .scan_en(scan_en),
        .y(y), .y_valid(y_valid), .sel_cur(sel_cur),
        .switch_pulse(switch_pulse), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit ld; int req; bit fs; bit scan;
        int y; int yv; int cur; int pulse; int err;
    } vec_t;

    vec_t tbl[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int m_cur, m_pend, m_pend_vld, m_err, m_pulse, m_y, m_yv;

    task automatic add(bit r, bit ld, int req, bit fs, bit sc, int ey, int ecur, int ep, int ee);
        vec_t v;
        v.rst = r; v.ld = ld; v.req = req; v.fs = fs; v.scan = sc;
        v.y = ey; v.yv = r ? 0 : 1; v.cur = ecur; v.pulse = ep; v.err = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan_val(int k);
        logic [NCH*WIDTH-1:0] sh;
        sh = d >> (k * WIDTH);
        return int'(sh[WIDTH-1:0]);
    endfunction

    task automatic model_update();
        int nxt;
        bit ok;
        if (rst) begin
            m_cur = 0; m_pend = 0; m_pend_vld = 0; m_err = 0; m_pulse = 0; m_y = 0; m_yv = 0;
        end else begin
            ok = sel_load && (int'(sel_req) < NCH);
            if (sel_load && !ok) m_err = 1;
            if (frame_start) begin
                if (ok)                       nxt = int'(sel_req);
                else if (m_pend_vld != 0)     nxt = m_pend;
                else if (SCAN != 0 && scan_en) nxt = (m_cur + 1) % NCH;
                else                          nxt = m_cur;
                m_pulse    = (nxt != m_cur) ? 1 : 0;
                m_cur      = nxt;
                m_pend_vld = 0;
            end else begin
                m_pulse = 0;
                if (ok) begin
                    m_pend = int'(sel_req);
                    m_pend_vld = 1;
                end
            end
            m_y  = chan_val(m_cur);
            m_yv = int'(d_valid[m_cur]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int c1, c2, c3, c4, cz;
        rst = 1'b1; sel_load = 1'b0; sel_req = '0; frame_start = 1'b0; scan_en = 1'b0;
        d_valid = '1;
        for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = WIDTH'(8'h10 + k);

        c1 = SCAN ? 4 : 3; c2 = SCAN ? 0 : 3; c3 = SCAN ? 1 : 3; c4 = SCAN ? 2 : 3;
        cz = SCAN ? 1 : 0;
        //  rst ld req fs scan  y          cur pulse err
        add(1, 0, 0, 0, 0, 'h00,      0,  0,    0);
        add(0, 0, 0, 0, 0, 'h10,      0,  0,    0);
        add(0, 1, 3, 0, 0, 'h10,      0,  0,    0);
        add(0, 0, 0, 0, 0, 'h10,      0,  0,    0);
        add(0, 0, 0, 1, 0, 'h13,      3,  1,    0);
        add(0, 0, 0, 0, 0, 'h13,      3,  0,    0);
        add(0, 1, 6, 0, 0, 'h13,      3,  0,    1);
        add(0, 0, 0, 1, 0, 'h13,      3,  0,    1);
        add(0, 1, 2, 0, 0, 'h13,      3,  0,    1);
        add(0, 0, 0, 1, 0, 'h12,      2,  1,    1);
        add(0, 1, 1, 1, 0, 'h11,      1,  1,    1);
        add(0, 1, 1, 1, 0, 'h11,      1,  0,    1);
        add(0, 1, 3, 0, 0, 'h11,      1,  0,    1);
        add(0, 0, 0, 1, 0, 'h13,      3,  1,    1);
        add(0, 0, 0, 1, 1, 'h10 + c1, c1, SCAN, 1);
        add(0, 0, 0, 1, 1, 'h10 + c2, c2, SCAN, 1);
        add(0, 0, 0, 1, 1, 'h10 + c3, c3, SCAN, 1);
        add(0, 0, 0, 1, 1, 'h10 + c4, c4, SCAN, 1);
        add(0, 1, 0, 0, 1, 'h10 + c4, c4, 0,    1);
        add(0, 0, 0, 1, 1, 'h10,      0,  1,    1);
        add(0, 0, 0, 1, 1, 'h10 + cz, cz, SCAN, 1);
        add(0, 1, 4, 0, 0, 'h10 + cz, cz, 0,    1);
        add(1, 1, 2, 1, 1, 'h00,      0,  0,    0);
        add(0, 0, 0, 1, 0, 'h10,      0,  0,    0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; sel_load = tbl[i].ld; sel_req = SELW'(tbl[i].req);
            frame_start = tbl[i].fs; scan_en = tbl[i].scan;
            cycle();
            chk($sformatf("vec%0d.y", i),     int'(y),            tbl[i].y);
            chk($sformatf("vec%0d.yv", i),    int'(y_valid),      tbl[i].yv);
            chk($sformatf("vec%0d.cur", i),   int'(sel_cur),      tbl[i].cur);
            chk($sformatf("vec%0d.pulse", i), int'(switch_pulse), tbl[i].pulse);
            chk($sformatf("vec%0d.err", i),   int'(sel_err),      tbl[i].err);
        end

        // rst with a request pending, then y_valid must track channel 0 valid
        rst = 1'b0; sel_load = 1'b1; sel_req = 3'd4; frame_start = 1'b0; cycle();
        sel_load = 1'b0; rst = 1'b1; cycle();
        rst = 1'b0; frame_start = 1'b1; d_valid = 5'b11110; cycle();
        chk("rstpend.cur", int'(sel_cur), 0);
        chk("rstpend.yv",  int'(y_valid), 0);
        frame_start = 1'b0; d_valid = 5'b00001; cycle();
        chk("rstpend.yv1", int'(y_valid), 1);
        chk("rstpend.y",   int'(y), 'h10);

        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            sel_load    = ($urandom_range(0, 3) == 0);
            sel_req     = SELW'($urandom_range(0, 7));
            frame_start = ($urandom_range(0, 5) == 0);
            scan_en     = ($urandom_range(0, 1) == 1);
            d_valid     = NCH'($urandom);
            for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            cycle();
            chk("rnd.y",     int'(y),            m_y);
            chk("rnd.yv",    int'(y_valid),      m_yv);
            chk("rnd.cur",   int'(sel_cur),      m_cur);
            chk("rnd.pulse", int'(switch_pulse), m_pulse);
            chk("rnd.err",   int'(sel_err),      m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
